// File: rtl/sysu_gate_tester.sv
// -----------------------------------------------------------------------------
// sysu_gate_tester
//   Self-test sequencer for a bank of WIDTH parallel inverter lanes. It sweeps
//   every stimulus pattern 0 .. 2^WIDTH-1 onto the lanes and holds each pattern
//   for SETTLE cycles so the gates can resolve. In the following SAMPLE cycle it
//   compares the lane outputs against ~STIM and records any failure.
//
// Parameters
//   WIDTH   number of inverter lanes (1..8); 2^WIDTH patterns per sweep
//   SETTLE  wait cycles after each stimulus update before sampling (>=1)
//
// Ports
//   CLK         rising-edge clock
//   RST_N       asynchronous active-low reset; a mid-sweep reset discards results
//   START       begin a sweep; only looked at while idle
//   STIM        registered stimulus driven to the gate inputs
//   RESP        gate outputs, treated as synchronous to CLK
//   BUSY        high while a sweep is in progress (settle, sample, finish)
//   DONE        one-cycle pulse marking the end of a sweep
//   PASS        last sweep finished with no failing pattern; held until START
//   ERR_CNT     number of failing patterns in the current/last sweep
//   FAIL_VALID  at least one failing pattern has been recorded
//   FIRST_FAIL  value of the first failing pattern, 0 when none
// -----------------------------------------------------------------------------
module sysu_gate_tester #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  output logic [WIDTH-1:0] STIM,
  input  logic [WIDTH-1:0] RESP,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [WIDTH:0]   ERR_CNT,
  output logic             FAIL_VALID,
  output logic [WIDTH-1:0] FIRST_FAIL
);

  // The settle counter only needs to reach SETTLE-1.
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE - 1);
  localparam logic [WIDTH-1:0] STIM_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] STIM_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] STIM_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH:0]   ERR_ZERO  = {(WIDTH + 1){1'b0}};
  localparam logic [WIDTH:0]   ERR_ONE   = (WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // A pattern fails when any lane is not the inverse of its stimulus bit.
  function automatic logic lane_mismatch(input logic [WIDTH-1:0] stim,
                                         input logic [WIDTH-1:0] resp);
    lane_mismatch = (resp != ~stim);
  endfunction

  state_t           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [WIDTH-1:0] stim_q,       stim_d;
  logic [WIDTH:0]   err_cnt_q,    err_cnt_d;
  logic             fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0] first_fail_q, first_fail_d;
  logic             pass_q,       pass_d;
  logic             busy_q,       busy_d;
  logic             done_q,       done_d;

  // Next-state and result bookkeeping for the sweep sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    stim_d       = stim_q;
    err_cnt_d    = err_cnt_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;
    pass_d       = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          stim_d       = STIM_ZERO;
          cnt_d        = CNT_ZERO;
          err_cnt_d    = ERR_ZERO;
          fail_valid_d = 1'b0;
          first_fail_d = STIM_ZERO;
          pass_d       = 1'b0;
          state_d      = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_SETTLE: begin
        // Counter holds at its last value; SAMPLE clears it for the next pattern.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_SAMPLE: begin
        if (lane_mismatch(stim_q, RESP)) begin
          err_cnt_d = err_cnt_q + ERR_ONE;
          if (!fail_valid_q) begin
            first_fail_d = stim_q;
            fail_valid_d = 1'b1;
          end else begin
            first_fail_d = first_fail_q;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end

        // STIM holds at the last pattern instead of wrapping.
        if (stim_q == STIM_MAX) begin
          state_d = ST_FINISH;
        end else begin
          stim_d  = stim_q + STIM_ONE;
          cnt_d   = CNT_ZERO;
          state_d = ST_SETTLE;
        end
      end

      ST_FINISH: begin
        pass_d  = (err_cnt_q == ERR_ZERO);
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so they register alongside it.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_FINISH);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      stim_q       <= STIM_ZERO;
      err_cnt_q    <= ERR_ZERO;
      fail_valid_q <= 1'b0;
      first_fail_q <= STIM_ZERO;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stim_q       <= stim_d;
      err_cnt_q    <= err_cnt_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
      pass_q       <= pass_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign STIM       = stim_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign PASS       = pass_q;
  assign ERR_CNT    = err_cnt_q;
  assign FAIL_VALID = fail_valid_q;
  assign FIRST_FAIL = first_fail_q;

endmodule
